// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the control unit and mult_div_unit.
// The control unit drives the master side; the multiply/divide unit is the slave.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             op_unsigned;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, op_unsigned, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, op_unsigned, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle radix-2 signed multiply/divide unit owning the HI/LO registers.
// Define MULTDIV_UNSIGNED_EN to honour op_unsigned (multu/divu); otherwise every op is signed.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          reset,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

  stateT            state, nextState;
  logic [CW-1:0]    count;
  logic             isDiv, zeroFlag, negResult, negRem;
  logic [WIDTH-1:0] operand, accHi, accLo;
  logic [WIDTH-1:0] hiReg, loReg;
  logic             doneReg, divZeroReg;

  logic             isUnsigned, signA, signB;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0]   addSum, shifted;
  logic [WIDTH-1:0] diff, stepHi, stepLo;
  logic             fits;
  logic [2*WIDTH-1:0] product;

`ifdef MULTDIV_UNSIGNED_EN
  assign isUnsigned = bus.op_unsigned;
`else
  logic unusedOpUnsigned;
  assign unusedOpUnsigned = bus.op_unsigned;
  assign isUnsigned       = 1'b0;
`endif

  // MIN negates to itself, which read as unsigned is exactly 2^(WIDTH-1).
  assign signA = bus.a[WIDTH-1] & ~isUnsigned;
  assign signB = bus.b[WIDTH-1] & ~isUnsigned;
  assign absA  = signA ? -bus.a : bus.a;
  assign absB  = signB ? -bus.b : bus.b;

  assign product = {accHi, accLo};

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    stepHi  = accHi;
    stepLo  = accLo;
    addSum  = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
    shifted = {accHi, accLo[WIDTH-1]};
    fits    = (shifted >= {1'b0, operand});
    diff    = shifted[WIDTH-1:0] - operand;
    if (isDiv) begin
      stepHi = fits ? diff : shifted[WIDTH-1:0];
      stepLo = {accLo[WIDTH-2:0], fits};
    end else begin
      stepHi = addSum[WIDTH:1];
      stepLo = {addSum[0], accLo[WIDTH-1:1]};
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (bus.start) nextState = (bus.op && bus.b == '0) ? FIX : RUN;
      RUN:     if (count == '0) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // NOTE: the iteration registers carry no reset; they are always loaded before being read.
  always_ff @(posedge clock) begin
    unique case (state)
      IDLE: if (bus.start) begin
        isDiv     <= bus.op;
        zeroFlag  <= bus.op && (bus.b == '0);
        negResult <= signA ^ signB;
        negRem    <= signA;
        operand   <= absB;
        accHi     <= '0;
        accLo     <= absA;
        count     <= CW'(WIDTH - 1);
      end
      RUN: begin
        accHi <= stepHi;
        accLo <= stepLo;
        count <= count - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hiReg      <= '0;
      loReg      <= '0;
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
    end else begin
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
      if (state == FIX) begin
        doneReg <= 1'b1;
        if (zeroFlag) begin
          divZeroReg <= 1'b1;
        end else if (isDiv) begin
          loReg <= negResult ? -accLo : accLo;
          hiReg <= negRem ? -accHi : accHi;
        end else begin
          {hiReg, loReg} <= negResult ? -product : product;
        end
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = doneReg;
  assign bus.div_zero = divZeroReg;
  assign bus.hi       = hiReg;
  assign bus.lo       = loReg;
endmodule
